twos_subtract_serial: RTL



---
 rtl/twos_subtract_serial_pkg.sv | 13 +
 rtl/twos_subtract_serial_fulladder.sv | 14 +
 rtl/twos_subtract_serial.sv | 112 +++++++++++
 3 files changed

// File: rtl/twos_subtract_serial_pkg.sv
// Shared ALU constants: default operand width and serial-subtractor state encodings.
package twos_subtract_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/twos_subtract_serial_fulladder.sv
// One-bit full adder cell, purely combinational (zero latency).
// No flow control; it is reused once per clock by the serial datapath.
module twos_subtract_serial_fulladder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/twos_subtract_serial.sv
// Bit-serial Z = X - Y (X + ~Y + 1), LSB first; done pulses WIDTH+1 cycles after start.
// start is only honoured in IDLE; requests during RUN/DONE are dropped, not queued.
module twos_subtract_serial
  import twos_subtract_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] zs;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cin_msb;
  logic             accept;
  logic             last;
  logic             y_inv;
  logic             fa_sum;
  logic             fa_cout;

  assign y_inv = ~ys[0];

  twos_subtract_serial_fulladder u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (xs[0]),
    .b    (y_inv),
    .cin  (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        last      = (cnt == CNT_LAST);
        state_nxt = last ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers only move on the final RUN edge, so the previous
  // answer stays visible throughout the next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs      <= '0;
      ys      <= '0;
      zs      <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      cin_msb <= 1'b0;
      Z       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      xs    <= X;
      ys    <= Y;
      zs    <= '0;
      cnt   <= '0;
      carry <= 1'b1;
    end else if (state == ST_RUN) begin
      xs    <= xs >> 1;
      ys    <= ys >> 1;
      zs    <= {fa_sum, zs[WIDTH-1:1]};
      carry <= fa_cout;
      cnt   <= cnt + 1'b1;
      if (cnt == CNT_PRE) cin_msb <= fa_cout;
      if (last) begin
        Z    <= {fa_sum, zs[WIDTH-1:1]};
        cout <= fa_cout;
        ovf  <= cin_msb ^ fa_cout;
      end
    end
  end

endmodule
